// File: rtl/audio_sample_pacer.sv
// Paces buffered stereo PCM out to the hdmi audio path at AUDIO_RATE.
// A fractional accumulator in the pixel clock domain produces the tick.
module audio_sample_pacer #(
    parameter int PIXEL_CLOCK_HZ = 74250000,
    parameter int AUDIO_RATE     = 48000,
    parameter int BIT_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                         clk_pixel,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [BIT_WIDTH-1:0]         s_left,
    input  logic [BIT_WIDTH-1:0]         s_right,
    output logic                         clk_audio,
    output logic [BIT_WIDTH-1:0]         audio_sample_word_l,
    output logic [BIT_WIDTH-1:0]         audio_sample_word_r,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [15:0]                  underrun_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic signed [31:0] STEP_UP = 32'(AUDIO_RATE);
    localparam logic signed [31:0] STEP_DN = 32'(AUDIO_RATE - PIXEL_CLOCK_HZ);

    logic signed [31:0]   acc_q, acc_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 ready_q, ready_d;
    logic [BIT_WIDTH-1:0] word_l_q, word_l_d;
    logic [BIT_WIDTH-1:0] word_r_q, word_r_d;
    logic [15:0]          under_q, under_d;
    logic                 tick_d1_q, tick_d1_d;
    logic                 aud_q, aud_d;

    logic [BIT_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [BIT_WIDTH-1:0] mem_r [FIFO_DEPTH];

    logic tick;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        tick  = enable & ~acc_q[31];
        empty = (level_q == '0);
        push  = s_valid & ready_q;
        // An empty FIFO never bypasses a same-cycle push to the words
        pop   = tick & ~empty;
    end

    always_comb begin
        acc_d = acc_q;
        if (enable) begin
            acc_d = acc_q + (tick ? STEP_DN : STEP_UP);
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        ready_d = (level_d != FULL_LVL);

        word_l_d = word_l_q;
        word_r_d = word_r_q;
        if (pop) begin
            word_l_d = mem_l[rd_ptr_q];
            word_r_d = mem_r[rd_ptr_q];
        end

        under_d = under_q;
        if (tick && empty && (under_q != 16'hFFFF)) begin
            under_d = under_q + 16'd1;
        end

        tick_d1_d = tick;
        aud_d     = tick_d1_q;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ready_q   <= 1'b0;
            word_l_q  <= '0;
            word_r_q  <= '0;
            under_q   <= '0;
            tick_d1_q <= 1'b0;
            aud_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ready_q   <= ready_d;
            word_l_q  <= word_l_d;
            word_r_q  <= word_r_d;
            under_q   <= under_d;
            tick_d1_q <= tick_d1_d;
            aud_q     <= aud_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem_l[wr_ptr_q] <= s_left;
            mem_r[wr_ptr_q] <= s_right;
        end
    end

    assign s_ready             = ready_q;
    assign clk_audio           = aud_q;
    assign audio_sample_word_l = word_l_q;
    assign audio_sample_word_r = word_r_q;
    assign fifo_level          = level_q;
    assign underrun_count      = under_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer with a sample-pair scoreboard
// and an independent tick-phase model.
module tb_audio_sample_pacer;

    localparam int PCH   = 74250000;
    localparam int AR    = 48000;
    localparam int BW    = 16;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [BW-1:0] l;
        logic [BW-1:0] r;
    } pair_t;

    logic          clk_pixel = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [BW-1:0] s_left = '0;
    logic [BW-1:0] s_right = '0;
    logic          clk_audio;
    logic [BW-1:0] wl;
    logic [BW-1:0] wr;
    logic [3:0]    fifo_level;
    logic [15:0]   underrun_count;

    audio_sample_pacer #(
        .PIXEL_CLOCK_HZ(PCH),
        .AUDIO_RATE(AR),
        .BIT_WIDTH(BW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .enable(enable),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_left(s_left),
        .s_right(s_right),
        .clk_audio(clk_audio),
        .audio_sample_word_l(wl),
        .audio_sample_word_r(wr),
        .fifo_level(fifo_level),
        .underrun_count(underrun_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint en_cyc;
    longint en_prev;

    always @(posedge clk_pixel) cyc <= cyc + 1;

    // Enabled cycles since reset; en_prev holds the value seen one edge ago
    always @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            en_cyc  <= 0;
            en_prev <= 0;
        end else begin
            en_prev <= en_cyc;
            en_cyc  <= en_cyc + (enable ? 1 : 0);
        end
    end

    pair_t         sb[$];
    pair_t         last_w;
    int            k_tick;
    int            exp_under;
    int            pulses;
    logic [BW-1:0] wl_p1, wr_p1, wl_p2, wr_p2;
    logic          ca_prev;

    function automatic longint tick_at(input int k);
        return (longint'(k) * PCH + AR - 1) / AR;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic on_pulse();
        pair_t e;
        pulses++;
        chk("tick_phase", en_prev, tick_at(k_tick) + 1);
        k_tick++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("word_l", wl, e.l);
            chk("word_r", wr, e.r);
            chk("word_l_at_e", wl_p1, e.l);
            chk("word_r_at_e", wr_p1, e.r);
            chk("word_l_before_e", wl_p2, last_w.l);
            chk("word_r_before_e", wr_p2, last_w.r);
            last_w = e;
        end else begin
            exp_under++;
            chk("underrun_count", underrun_count, exp_under);
            chk("word_l_hold", wl, last_w.l);
            chk("word_r_hold", wr, last_w.r);
        end
    endtask

    task automatic cycle();
        @(negedge clk_pixel);
        if (clk_audio === 1'b1) begin
            chk("pulse_width", ca_prev, 0);
            on_pulse();
        end
        ca_prev = clk_audio;
        wl_p2 = wl_p1;
        wr_p2 = wr_p1;
        wl_p1 = wl;
        wr_p1 = wr;
    endtask

    task automatic wait_pulse(input int bound);
        int p0;
        p0 = pulses;
        for (int i = 0; i < bound && pulses == p0; i++) cycle();
        chk("pulse_seen", pulses - p0, 1);
    endtask

    task automatic push(input logic [BW-1:0] l, input logic [BW-1:0] r);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        chk("push_ready", s_ready, 1);
        if (s_ready === 1'b1) sb.push_back('{l: l, r: r});
        cycle();
        s_valid = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        last_w    = '0;
        exp_under = 0;
        k_tick    = 0;
    endtask

    initial begin
        longint        n0;
        longint        ta;
        int            ka;
        int            acc_n;
        int            p0;
        logic [BW-1:0] hl, hr;
        logic [3:0]    hlev;

        model_reset();
        pulses  = 0;
        ca_prev = 1'b0;
        wl_p1 = '0; wr_p1 = '0; wl_p2 = '0; wr_p2 = '0;

        #12;
        chk("rst_word_l", wl, 0);
        chk("rst_word_r", wr, 0);
        chk("rst_clk_audio", clk_audio, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_underrun", underrun_count, 0);
        chk("rst_ready", s_ready, 0);
        cycle();
        cycle();
        reset = 1'b0;
        chk("ready_before_edge", s_ready, 0);
        cycle();
        chk("ready_after_edge", s_ready, 1);

        // Data path
        push(16'hA947, 16'hA946);
        push(16'h1234, 16'h5678);
        cycle();
        chk("level_two", fifo_level, 2);
        n0 = cyc;
        enable = 1'b1;
        wait_pulse(10);
        chk("first_tick_cycle", cyc, n0 + 2);
        chk("level_after_pop", fifo_level, 1);
        ta = cyc;
        wait_pulse(2000);
        chk("second_gap", cyc - ta, 1547);

        // Underrun: no more pushes
        for (int i = 0; i < 11; i++) wait_pulse(2000);
        chk("underrun_total", underrun_count, 11);

        // Backpressure
        enable = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_left  = 16'h1000 + 16'(i);
            s_right = 16'h2000 + 16'(i);
            if (s_ready === 1'b1) begin
                acc_n++;
                sb.push_back('{l: s_left, r: s_right});
            end
            cycle();
        end
        s_valid = 1'b0;
        cycle();
        chk("bp_accepted", acc_n, 8);
        chk("bp_level", fifo_level, 8);
        chk("bp_ready", s_ready, 0);
        enable = 1'b1;
        wait_pulse(2000);
        chk("bp_level_pop", fifo_level, 7);
        chk("bp_ready_back", s_ready, 1);

        // Enable gating
        ta = cyc;
        ka = k_tick;
        repeat (500) cycle();
        enable = 1'b0;
        hl = wl;
        hr = wr;
        hlev = fifo_level;
        p0 = pulses;
        repeat (3000) cycle();
        chk("gate_no_pulse", pulses - p0, 0);
        chk("gate_word_l", wl, hl);
        chk("gate_word_r", wr, hr);
        chk("gate_level", fifo_level, hlev);
        enable = 1'b1;
        wait_pulse(3000);
        chk("gate_gap", cyc - ta, tick_at(ka) - tick_at(ka - 1) + 3000);
        chk("gate_level_pop", fifo_level, 6);
        wait_pulse(2000);
        chk("pre_reset_level", fifo_level, 5);

        // Asynchronous reset between edges
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("async_word_l", wl, 0);
        chk("async_word_r", wr, 0);
        chk("async_clk_audio", clk_audio, 0);
        chk("async_level", fifo_level, 0);
        chk("async_underrun", underrun_count, 0);
        chk("async_ready", s_ready, 0);
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        chk("ready_after_rerst", s_ready, 1);
        n0 = cyc;
        enable = 1'b1;
        wait_pulse(10);
        chk("rerst_first_tick", cyc, n0 + 2);
        chk("rerst_underrun", underrun_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
